// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_t          : fetch FSM states
//   FETCH_MAX_WAIT_DEFAULT : default memory-response timeout in cycles
package fetch_pkg;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_WAIT  = 2'd1,
        F_DRAIN = 2'd2
    } fetch_state_t;

    localparam int unsigned FETCH_MAX_WAIT_DEFAULT = 16;

endpackage

// File: rtl/fetch_wait_timer.sv
// Memory wait-state counter for the fetch sequencer.
//   clk, reset : clock, asynchronous active-high reset
//   clear_i    : zero the count (takes priority over en_i)
//   en_i       : one more un-acknowledged read cycle
//   timeout_o  : this enabled cycle is the MAX_WAIT-th consecutive one
module fetch_wait_timer #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam int unsigned W = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] SAT  = W'(MAX_WAIT);
    localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag the timeout in the cycle that would be the MAX_WAIT-th miss, so
    // the FSM leaves after exactly MAX_WAIT cycles of mem_rd_en.
    assign timeout_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: issues a word read at pc, waits for the memory response
// and hands the word to the instruction register.
//   clk, reset      : clock, asynchronous active-high reset
//   fetch_req, pc   : fetch request and address (sampled in F_IDLE)
//   flush           : abort the outstanding fetch, discarding its response
//   mem_addr        : registered read address
//   mem_rd_en       : read request, high while a read is outstanding
//   mem_ready       : memory response valid
//   mem_rd_data     : memory read data
//   rd_data         : registered instruction word
//   ir_write        : one-cycle pulse, rd_data valid
//   fetch_busy      : read outstanding
//   misaligned      : one-cycle pulse, request had pc[1:0] != 0
//   bus_err         : one-cycle pulse, memory timeout
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned MAX_WAIT = FETCH_MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic        mem_ready,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] rd_data,
    output logic        ir_write,
    output logic        fetch_busy,
    output logic        misaligned,
    output logic        bus_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [31:0]  rd_data_q, rd_data_d;
    logic         ir_write_q, ir_write_d;
    logic         misaligned_q, misaligned_d;
    logic         bus_err_q, bus_err_d;
    logic         timeout;

    fetch_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == F_IDLE),
        .en_i     ((state_q != F_IDLE) && !mem_ready),
        .timeout_o(timeout)
    );

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        rd_data_d    = rd_data_q;
        ir_write_d   = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        unique case (state_q)
            F_IDLE: begin
                if (!flush && fetch_req) begin
                    if (pc[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                    end else begin
                        mem_addr_d = pc;
                        state_d    = F_WAIT;
                    end
                end
            end
            F_WAIT: begin
                if (mem_ready) begin
                    if (!flush) begin
                        rd_data_d  = mem_rd_data;
                        ir_write_d = 1'b1;
                    end
                    state_d = F_IDLE;
                end else if (timeout) begin
                    // Timeout wins over a simultaneous flush.
                    bus_err_d = 1'b1;
                    state_d   = F_IDLE;
                end else if (flush) begin
                    state_d = F_DRAIN;
                end
            end
            F_DRAIN: begin
                if (mem_ready) begin
                    state_d = F_IDLE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= F_IDLE;
            mem_addr_q   <= '0;
            rd_data_q    <= '0;
            ir_write_q   <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            rd_data_q    <= rd_data_d;
            ir_write_q   <= ir_write_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd_en  = (state_q != F_IDLE);
    assign fetch_busy = mem_rd_en;
    assign rd_data    = rd_data_q;
    assign ir_write   = ir_write_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int MW = 4;
    localparam int EV_IR = 0, EV_MIS = 1, EV_BERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_ready;
    logic [31:0] mem_rd_data;
    logic [31:0] rd_data;
    logic        ir_write;
    logic        fetch_busy;
    logic        misaligned;
    logic        bus_err;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    ev_t         q[$];
    logic [31:0] last_rd = '0;

    instr_fetch_unit #(.MAX_WAIT(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .flush      (flush),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_ready  (mem_ready),
        .mem_rd_data(mem_rd_data),
        .rd_data    (rd_data),
        .ir_write   (ir_write),
        .fetch_busy (fetch_busy),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: whenever a pulse output is seen, pop the expected event.
    int   mon_n;
    int   mon_kind;
    ev_t  mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            mon_n = int'(ir_write) + int'(misaligned) + int'(bus_err);
            if (mon_n > 1) chk("pulse_exclusive", mon_n, 1);
            if (mon_n >= 1) begin
                mon_kind = ir_write ? EV_IR : (misaligned ? EV_MIS : EV_BERR);
                if (q.size() == 0) begin
                    chk("spurious_pulse_kind", mon_kind, 32'hFFFF_FFFF);
                end else begin
                    mon_e = q.pop_front();
                    chk("event_kind", mon_kind, mon_e.kind);
                    chk("event_cycle", cyc, mon_e.cyc);
                    if (mon_e.kind == EV_IR) chk("ir_rd_data", rd_data, mon_e.data);
                end
            end
        end
    end

    function automatic ev_t mk(input int kind, input logic [31:0] data, input int c);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = c;
        return e;
    endfunction

    // One fetch transaction; the bench plays the memory. Called #1 after a
    // posedge with the DUT idle. lat = wait cycles before mem_ready,
    // fl = wait-cycle index where flush is first raised (-1 none),
    // fidle = raise flush together with fetch_req.
    task automatic do_fetch(input logic [31:0] a, input int lat, input int fl,
                            input logic [31:0] dat, input bit fidle);
        int n;
        chk("idle_rd_en", mem_rd_en, 0);
        chk("idle_busy", fetch_busy, 0);
        fetch_req = 1'b1;
        pc        = a;
        flush     = fidle;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        flush     = 1'b0;
        if (fidle) return;
        if (a[1:0] != 2'b00) begin
            q.push_back(mk(EV_MIS, '0, cyc));
            return;
        end
        n = (lat >= MW) ? MW : lat + 1;
        for (int i = 0; i < n; i++) begin
            chk("wait_rd_en", mem_rd_en, 1);
            chk("wait_busy", fetch_busy, 1);
            chk("wait_addr", mem_addr, a);
            mem_ready   = (i == lat);
            mem_rd_data = (i == lat) ? dat : $urandom;
            flush       = (i == fl) || (fl >= 0 && i > fl && ($urandom % 2 == 1));
            fetch_req   = ($urandom % 2 == 1);
            pc          = $urandom;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        flush     = 1'b0;
        fetch_req = 1'b0;
        if (lat >= MW) begin
            q.push_back(mk(EV_BERR, '0, cyc));
        end else if (fl >= 0 && fl <= lat) begin
            // discarded
        end else begin
            q.push_back(mk(EV_IR, dat, cyc));
            last_rd = dat;
        end
        if (!(lat < MW && !(fl >= 0 && fl <= lat))) chk("rd_data_hold", rd_data, last_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int r, lat, fl, gap;
        reset = 1'b1; fetch_req = 1'b0; pc = '0; flush = 1'b0;
        mem_ready = 1'b0; mem_rd_data = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_busy", fetch_busy, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the plan.
        do_fetch(32'h0000_0010, 0, -1, 32'h0050_0093, 1'b0);   // zero wait
        do_fetch(32'h0000_0014, 3, -1, 32'h1234_5678, 1'b0);   // 3 wait states
        do_fetch(32'h0000_0018, 1, -1, 32'hCAFE_0001, 1'b0);   // back-to-back
        do_fetch(32'h0000_0006, 0, -1, 32'h0, 1'b0);           // misaligned
        do_fetch(32'h0000_0020, 3, 1, 32'hDEAD_BEEF, 1'b0);    // flush then drain
        do_fetch(32'h0000_0024, 5, -1, 32'h0, 1'b0);           // timeout
        do_fetch(32'h0000_0028, 3, -1, 32'hBEEF_0003, 1'b0);   // ready on last allowed cycle
        do_fetch(32'h0000_002C, 0, -1, 32'h0, 1'b1);           // flush in idle drops req

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            r = $urandom % 10;
            a = $urandom;
            if (r == 0) begin
                a[1:0] = 2'(1 + $urandom % 3);
                do_fetch(a, 0, -1, '0, 1'b0);
            end else if (r == 1) begin
                do_fetch(a, 0, -1, '0, 1'b1);
            end else begin
                a[1:0] = 2'b00;
                lat = $urandom % 6;
                fl  = ($urandom % 3 == 0) ? int'($urandom % (lat + 1)) : -1;
                do_fetch(a, lat, fl, $urandom, 1'b0);
            end
            gap = $urandom % 3;
            for (int g = 0; g < gap; g++) begin
                flush = ($urandom % 2 == 1);
                @(posedge clk); #1;
                flush = 1'b0;
            end
        end

        // Async reset in the middle of a wait.
        @(posedge clk); #1;
        chk("pre_reset_queue_empty", q.size(), 0);
        fetch_req = 1'b1; pc = 32'h0000_0040;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        chk("pre_reset_rd_en", mem_rd_en, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_rd_en", mem_rd_en, 0);
        chk("async_rst_busy", fetch_busy, 0);
        chk("async_rst_rd_data", rd_data, 0);
        chk("async_rst_mem_addr", mem_addr, 0);
        last_rd = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_fetch(32'h0000_0044, 1, -1, 32'h00A0_0113, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("final_queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch sequencer for the multicycle RISC-V core: on a request from the control unit it issues a word read to instruction memory at the current PC. It waits a variable number of cycles for the memory response, then presents the word with a one-cycle `ir_write` pulse to the instruction register. It also handles misaligned PCs, pipeline flushes of an outstanding read, and memory timeouts.

## Interface
Parameters:
- `MAX_WAIT`, 16: consecutive un-acknowledged read cycles before a bus error; must be ≥ 1.

Ports:
- `clk`  in  1  single clock, all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `fetch_req`  in  1  control unit requests a fetch; sampled only in F_IDLE.
- `pc`  in  32  fetch address; sampled with `fetch_req`.
- `flush`  in  1  abort any outstanding fetch; the response is discarded.
- `mem_addr`  out  32  registered read address.
- `mem_rd_en`  out  1  read request; held high until `mem_ready`.
- `mem_ready`  in  1  memory response valid this cycle (only meaningful while `mem_rd_en`=1).
- `mem_rd_data`  in  32  read data, valid when `mem_ready`=1.
- `rd_data`  out  32  registered instruction word to the IR.
- `ir_write`  out  1  one-cycle pulse; `rd_data` is valid in the same cycle.
- `fetch_busy`  out  1  high in F_WAIT and F_DRAIN.
- `misaligned`  out  1  one-cycle pulse: the request had `pc[1:0]` ≠ 0.
- `bus_err`  out  1  one-cycle pulse: timeout.

## Operation
- States: F_IDLE, F_WAIT, F_DRAIN.
- F_IDLE, `flush`=1: stay. Any `fetch_req` in the same cycle is dropped.
- F_IDLE, `fetch_req`=1, `pc[1:0]`=0: latch `mem_addr`<=`pc`, clear `wait_cnt`, go to F_WAIT.
- F_IDLE, `fetch_req`=1, `pc[1:0]`≠0: no memory access; `misaligned` pulses next cycle; stay in F_IDLE.
- F_WAIT, `mem_ready`=1, `flush`=0: `rd_data`<=`mem_rd_data`; `ir_write` pulses next cycle; go to F_IDLE.
- F_WAIT, `mem_ready`=1, `flush`=1: discard the data, no `ir_write`; go to F_IDLE.
- F_WAIT, `mem_ready`=0, `flush`=1: go to F_DRAIN. `mem_rd_en` stays high so the memory transaction completes.
- F_DRAIN, `mem_ready`=1: discard the data; go to F_IDLE. `flush` has no further effect here.
- `wait_cnt` increments on each F_WAIT/F_DRAIN cycle with `mem_ready`=0. It is `$clog2(MAX_WAIT+1)` bits wide and saturates without wrapping.
- Timeout: on the `MAX_WAIT`-th consecutive cycle with `mem_ready`=0, go to F_IDLE and pulse `bus_err` next cycle. `ir_write` does not pulse.
- `fetch_req` in F_WAIT/F_DRAIN is ignored (not queued).
- `mem_rd_en` = (state ≠ F_IDLE); `fetch_busy` = `mem_rd_en`.
- `rd_data` holds its last value between fetches; it is not cleared on flush.

## Timing
- Reset values: state F_IDLE, `mem_addr`=0, `rd_data`=0, `wait_cnt`=0, `mem_rd_en`/`fetch_busy`/`ir_write`/`misaligned`/`bus_err`=0.
- Request at edge N: `mem_rd_en`=1 from cycle N+1. If `mem_ready`=1 in cycle N+1, `ir_write`=1 in cycle N+2. Minimum latency is 2 cycles; each memory wait cycle adds 1.
- `ir_write` is asserted in the first F_IDLE cycle. A `fetch_req` in that cycle is accepted, so back-to-back throughput is 1 fetch per 2 cycles.
- `ir_write`, `misaligned` and `bus_err` are registered, mutually exclusive, and each lasts exactly 1 cycle.
- `reset` mid-transaction forces F_IDLE and drops `mem_rd_en` asynchronously. The memory must tolerate the abandoned request.

## Structure
- `fetch_pkg`: enum `fetch_state_t` {F_IDLE, F_WAIT, F_DRAIN}, and constant `FETCH_MAX_WAIT_DEFAULT` = 16.
- One sub-module, `fetch_wait_timer`: counter with clear, count-enable and timeout flag, parameterised by `MAX_WAIT`.
- The FSM and output registers stay in `instr_fetch_unit`.

## Test plan
- Zero-wait fetch: `pc`=0x0000_0010, `fetch_req` at cycle 0; `mem_ready`=1, `mem_rd_data`=0x0050_0093 at cycle 1 → `mem_addr`=0x10 and `mem_rd_en`=1 at cycle 1; `ir_write`=1 and `rd_data`=0x0050_0093 at cycle 2 only.
- Wait states: memory asserts `mem_ready` 3 cycles late → `mem_rd_en` high for 4 cycles, `ir_write` on the following cycle; a second `fetch_req` in the `ir_write` cycle is accepted.
- Misaligned: `pc`=0x0000_0006 with `fetch_req` → `mem_rd_en` never asserts; `misaligned`=1 for exactly 1 cycle; state remains F_IDLE.
- Flush: `flush` in the 2nd F_WAIT cycle, `mem_ready` 2 cycles later → `mem_rd_en` stays high until `mem_ready`; no `ir_write`; `rd_data` unchanged.
- Timeout: `MAX_WAIT`=4, `mem_ready` never asserted → `mem_rd_en` high exactly 4 cycles, `bus_err` pulses once, `ir_write` never asserts.
- Async reset asserted mid-F_WAIT → `mem_rd_en`=0 before the next edge; after release, a new fetch completes normally.
